// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame FIFO writer: descriptor layout,
// FSM state encoding and default frame length limits.
`default_nettype none

package frame_pkg;

  localparam int DEF_LEN_WIDTH = 11;
  localparam int DEF_MIN_LEN   = 64;
  localparam int DEF_MAX_LEN   = 1522;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_TRUNC = 2'd2,
    ST_DROP  = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic                     err;
    logic                     runt;
    logic                     trunc;
    logic [DEF_LEN_WIDTH-1:0] len;
  } frame_desc_t;

endpackage

`default_nettype wire

// File: rtl/frame_fifo_writer.sv
// Admits, truncates or drops RX MAC frames and issues zero-latency writes
// to the data FIFO plus one descriptor per admitted frame.
`default_nettype none

module frame_fifo_writer
  import frame_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int P_MIN_LEN    = DEF_MIN_LEN,
  parameter int P_MAX_LEN    = DEF_MAX_LEN,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    rx_valid_i,
  input  logic [P_DATA_WIDTH-1:0] rx_data_i,
  input  logic                    rx_sof_i,
  input  logic                    rx_eof_i,
  input  logic                    rx_err_i,
  output logic                    data_wr_o,
  output logic [P_DATA_WIDTH-1:0] data_o,
  input  logic                    data_full_i,
  output logic                    desc_wr_o,
  output logic [P_LEN_WIDTH+2:0]  desc_o,
  input  logic                    desc_full_i,
  output logic [P_CNT_WIDTH-1:0]  frame_cnt_o,
  output logic [P_CNT_WIDTH-1:0]  drop_cnt_o
);

  localparam logic [P_LEN_WIDTH-1:0] MAX_LEN_L = P_LEN_WIDTH'(P_MAX_LEN);
  localparam logic [P_LEN_WIDTH-1:0] MIN_LEN_L = P_LEN_WIDTH'(P_MIN_LEN);

  logic                   rst_meta, rst_sync_n, run;
  frame_state_t           state_q, state_d;
  logic [P_LEN_WIDTH-1:0] len_q, len_d;
  logic                   trunc_q, trunc_d;
  logic [P_CNT_WIDTH-1:0] frame_cnt_q, drop_cnt_q;

  logic                   data_wr, desc_req, desc_wr, drop_inc, can_write;
  logic                   d_err, d_trunc;
  logic [P_LEN_WIDTH-1:0] d_len;

  // run mirrors rst_sync_n so the write gates never share a net with the async reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
      run        <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
      run        <= rst_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      trunc_q     <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      if (desc_wr)  frame_cnt_q <= frame_cnt_q + P_CNT_WIDTH'(1);
      if (drop_inc) drop_cnt_q  <= drop_cnt_q + P_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    trunc_d   = trunc_q;
    data_wr   = 1'b0;
    desc_req  = 1'b0;
    drop_inc  = 1'b0;
    can_write = 1'b0;
    d_err     = 1'b0;
    d_trunc   = 1'b0;
    d_len     = '0;

    if (rx_valid_i && run) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_sof_i) begin
            if (!data_full_i && !desc_full_i) begin
              data_wr = 1'b1;
              len_d   = P_LEN_WIDTH'(1);
              trunc_d = 1'b0;
              if (rx_eof_i) begin
                desc_req = 1'b1;
                d_err    = rx_err_i;
                d_len    = P_LEN_WIDTH'(1);
              end else begin
                state_d = ST_RECV;
              end
            end else begin
              drop_inc = 1'b1;
              if (!rx_eof_i) state_d = ST_DROP;
            end
          end
        end

        ST_RECV, ST_TRUNC: begin
          if (rx_sof_i) begin
            // Missing EOF: close the open frame as errored, discard the new one
            desc_req = 1'b1;
            d_err    = 1'b1;
            d_trunc  = trunc_q;
            d_len    = len_q;
            drop_inc = 1'b1;
            state_d  = rx_eof_i ? ST_IDLE : ST_DROP;
          end else begin
            can_write = (state_q == ST_RECV) && !data_full_i && (len_q < MAX_LEN_L);
            data_wr   = can_write;
            if (can_write) begin
              len_d = len_q + P_LEN_WIDTH'(1);
            end else if (state_q == ST_RECV) begin
              trunc_d = 1'b1;
              state_d = ST_TRUNC;
            end
            if (rx_eof_i) begin
              desc_req = 1'b1;
              d_err    = rx_err_i;
              d_trunc  = trunc_q | ~can_write;
              d_len    = len_q + {{(P_LEN_WIDTH-1){1'b0}}, can_write};
              state_d  = ST_IDLE;
            end
          end
        end

        ST_DROP: begin
          if (rx_eof_i) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    desc_wr = desc_req & ~desc_full_i;
  end

  assign data_wr_o   = data_wr;
  assign data_o      = rx_data_i;
  assign desc_wr_o   = desc_wr;
  assign desc_o      = {d_err, (d_len < MIN_LEN_L), d_trunc, d_len};
  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

`default_nettype wire

// File: doc/frame_fifo_writer.md
Name: frame_fifo_writer

Overview:
Upstream stage of the switch's per-port frame buffer. Takes a byte stream from the RX MAC and writes frame bytes into a data sync_fifo_core instance. Pushes one descriptor per admitted frame into a second sync_fifo_core instance. Admits, truncates or drops frames so that the data FIFO and the descriptor FIFO never desynchronise.

Parameters:
P_DATA_WIDTH, 8, width of one stream beat and of the data FIFO word
P_LEN_WIDTH, 11, frame length counter width in beats
P_MIN_LEN, 64, frames shorter than this are flagged runt
P_MAX_LEN, 1522, beats beyond this are not written and the frame is flagged trunc
P_CNT_WIDTH, 16, statistics counter width

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
rx_valid_i  in  1  beat valid; no backpressure to the MAC
rx_data_i  in  P_DATA_WIDTH  beat data
rx_sof_i  in  1  first beat of frame, qualified by rx_valid_i
rx_eof_i  in  1  last beat of frame, qualified by rx_valid_i
rx_err_i  in  1  MAC error (FCS/PHY), sampled on the EOF beat
data_wr_o  out  1  write strobe to the data FIFO wr_i
data_o  out  P_DATA_WIDTH  to the data FIFO data_i; equals rx_data_i
data_full_i  in  1  data FIFO full_o
desc_wr_o  out  1  write strobe to the descriptor FIFO wr_i
desc_o  out  P_LEN_WIDTH+3  {err, runt, trunc, len[P_LEN_WIDTH-1:0]}
desc_full_i  in  1  descriptor FIFO full_o
frame_cnt_o  out  P_CNT_WIDTH  descriptors written, wraps
drop_cnt_o  out  P_CNT_WIDTH  frames dropped at admission, wraps

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE, len_q=0, trunc_q=0, both counters 0. data_wr_o and desc_wr_o are 0 while in reset. The FIFOs share rstn_i, so partial frames are cleared system-wide.
- data_wr_o, data_o, desc_wr_o and desc_o are combinational from the current beat and the registered state, giving zero-latency writes. This lets the FIFO full flags act on the same cycle.
- FSM states: IDLE, RECV, TRUNC, DROP.
- IDLE, beat without SOF: ignored, no writes.
- IDLE, SOF beat with desc_full_i=0 and data_full_i=0: admit.
  - Write the beat and set len_q=1.
  - If EOF is on the same beat, write the descriptor with len=1, runt=1, and stay IDLE.
  - Otherwise go to RECV.
- IDLE, SOF beat with either full flag set: no writes, drop_cnt_o+1, go to DROP. If EOF is on the same beat, stay IDLE.
- RECV, beat with data_full_i=0 and len_q<P_MAX_LEN: write the beat, len_q+1.
- RECV, beat with data_full_i=1 or len_q==P_MAX_LEN: no write, set trunc_q, go to TRUNC.
- RECV/TRUNC, EOF beat:
  - desc_wr_o=1 in the same cycle, frame_cnt_o+1, go to IDLE.
  - len = len_q + (beat written this cycle).
  - err = rx_err_i, runt = (len<P_MIN_LEN), trunc = trunc_q or (this beat not written).
- TRUNC: beats are never written, even if data_full_i deasserts.
- DROP: beats ignored. An EOF beat returns to IDLE.
- SOF while in RECV/TRUNC (missing EOF):
  - Close the current frame with a descriptor, err=1, len=len_q.
  - The SOF beat itself is not written; drop_cnt_o+1, go to DROP.
- The descriptor FIFO is checked only at admission. One writer and one descriptor per admitted frame guarantee a slot at EOF.
- The data FIFO is never written when data_full_i=1. The descriptor FIFO is never written when desc_full_i=1.
- rx_valid_i=0 cycles anywhere: no state change, no writes.

Decomposition:
- Package frame_pkg holds:
  - a packed struct typedef frame_desc_t {err, runt, trunc, len};
  - the FSM state enum;
  - constants for the default min/max length.
- No sub-module. FIFOs are instantiated at the port-buffer level, not inside this block.

Test Plan:
- 100-beat frame, FIFOs empty -> 100 data writes in the same cycles as the beats; one descriptor at the EOF cycle {0,0,0,100}; frame_cnt_o=1.
- Single beat with SOF+EOF and rx_err_i=1 -> one data write; descriptor {1,1,0,1}.
- 1600-beat frame -> exactly 1522 data writes; descriptor {0,0,1,1522}.
- data_full_i rises after beat 40 of an 80-beat frame and falls at beat 60 -> 40 writes total; descriptor trunc=1, len=40.
- desc_full_i=1 at SOF of a 70-beat frame -> zero writes of either kind; drop_cnt_o=1; the next frame is admitted once desc_full_i=0.
- SOF at beat 30 of an open frame -> descriptor {1,1,0,29} on the SOF cycle and the rest is dropped. Separately, rstn_i pulsed mid-frame -> outputs go to 0 immediately; the next SOF is admitted normally.
